// File: rtl/encoder_hex_to_bin_pkg.sv
// Shared widths, reset code and helpers for the hex-to-binary encoder.
package encoder_hex_to_bin_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 4;

    localparam logic [OUT_W-1:0] RST_CODE = 4'h0;

    // True when more than one bit is set: clearing the lowest set bit leaves a remainder.
    function automatic logic is_multi(input logic [IN_W-1:0] v);
        return (v & (v - IN_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/encoder_hex_to_bin_prio_enc16.sv
// Combinational 16-to-4 priority encoder; PRIORITY_MSB picks which end wins on multi-hot input.
module prio_enc16
    import encoder_hex_to_bin_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] code,
    output logic             any,
    output logic             multi
);

    always_comb begin
        code = RST_CODE;
        // Full scan; the last match in scan order wins.
        if (PRIORITY_MSB) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in[i]) code = OUT_W'(i);
            end
        end else begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (in[i]) code = OUT_W'(i);
            end
        end
        any   = |in;
        multi = is_multi(in);
    end

endmodule

// File: rtl/encoder_hex_to_bin.sv
// Registered one-hot to binary encoder with zero detect.
// Optional one-hot checker (err / err_sticky) enabled by ENCODER_HEX_TO_BIN_ONEHOT_CHECK_EN.
module encoder_hex_to_bin
    import encoder_hex_to_bin_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             err,
    output logic             err_sticky
);

    logic [OUT_W-1:0] enc_code;
    logic             enc_any;
    logic             enc_multi;

    prio_enc16 #(.PRIORITY_MSB(PRIORITY_MSB)) u_prio_enc16 (
        .in    (in),
        .code  (enc_code),
        .any   (enc_any),
        .multi (enc_multi)
    );

    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        zero_d      = 1'b0;
        if (in_valid) begin
            if (enc_any) begin
                out_d       = enc_code;
                out_valid_d = 1'b1;
            end else begin
                zero_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= RST_CODE;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
        end
    end

`ifdef ENCODER_HEX_TO_BIN_ONEHOT_CHECK_EN
    logic err_q, err_d;
    logic err_sticky_q, err_sticky_d;

    // The sticky flag rises in the same cycle as the err pulse that sets it.
    always_comb begin
        err_d        = in_valid & enc_multi;
        err_sticky_d = err_sticky_q | err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;
`else
    logic unused_multi;
    assign unused_multi = enc_multi;
    assign err          = 1'b0;
    assign err_sticky   = 1'b0;
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_encoder_hex_to_bin.sv
// Scoreboard bench: driver pushes hand-computed expectations, monitor pops and compares each cycle.
module tb_encoder_hex_to_bin;

`ifdef ENCODER_HEX_TO_BIN_ONEHOT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_v = 16'h0000;
    logic        in_valid = 1'b0;

    logic [3:0]  out_m, out_l;
    logic        ov_m, ov_l, zero_m, zero_l, err_m, err_l, stk_m, stk_l;

    always #5 clk = ~clk;

    encoder_hex_to_bin #(.PRIORITY_MSB(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in(in_v), .in_valid(in_valid),
        .out(out_m), .out_valid(ov_m), .zero(zero_m), .err(err_m), .err_sticky(stk_m)
    );

    encoder_hex_to_bin #(.PRIORITY_MSB(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in(in_v), .in_valid(in_valid),
        .out(out_l), .out_valid(ov_l), .zero(zero_l), .err(err_l), .err_sticky(stk_l)
    );

    typedef struct {
        logic [3:0] om;
        logic [3:0] ol;
        logic       ov;
        logic       z;
        logic       e;
        logic       s;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sticky_m = 1'b0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    // One cycle of stimulus plus the response expected after the next rising edge.
    task automatic step(input logic [15:0] d, input logic v, input logic r,
                        input logic [3:0] em, input logic [3:0] el,
                        input logic ov, input logic z, input logic m);
        exp_t x;
        @(negedge clk);
        in_v     = d;
        in_valid = v;
        rst      = r;
        x.om = em;
        x.ol = el;
        x.ov = ov;
        x.z  = z;
        x.e  = m & CHK;
        sticky_m = r ? 1'b0 : (sticky_m | x.e);
        x.s  = sticky_m;
        q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        cyc++;
        if (q.size() != 0) begin
            x = q.pop_front();
            chk("out_msb",        out_m,         x.om);
            chk("out_lsb",        out_l,         x.ol);
            chk("out_valid",      {3'b0, ov_m},  {3'b0, x.ov});
            chk("out_valid_lsb",  {3'b0, ov_l},  {3'b0, x.ov});
            chk("zero",           {3'b0, zero_m}, {3'b0, x.z});
            chk("zero_lsb",       {3'b0, zero_l}, {3'b0, x.z});
            chk("err",            {3'b0, err_m}, {3'b0, x.e});
            chk("err_lsb",        {3'b0, err_l}, {3'b0, x.e});
            chk("err_sticky",     {3'b0, stk_m}, {3'b0, x.s});
            chk("err_sticky_lsb", {3'b0, stk_l}, {3'b0, x.s});
        end
    end

    initial begin
        // Reset wins over a valid multi-hot sample in the same cycle.
        step(16'h1234, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h1234, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(16'h0001 << i, 1'b1, 1'b0, 4'(i), 4'(i), 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        step(16'h0081, 1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0, 1'b1);
        step(16'h0400, 1'b1, 1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 1'b0, 1'b0, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0);
        step(16'hFFFF, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(16'h0001 << i, 1'b1, 1'b0, 4'(i), 4'(i), 1'b1, 1'b0, 1'b0);
        // Reset mid-walk discards 0x0040, then the walk resumes from bit 6.
        step(16'h0040, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i < 16; i++)
            step(16'h0001 << i, 1'b1, 1'b0, 4'(i), 4'(i), 1'b1, 1'b0, 1'b0);
        step(16'hC000, 1'b1, 1'b0, 4'hF, 4'hE, 1'b1, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 4'hF, 4'hE, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
